dkong_dma_nch: RTL and testbench
================================

Name: dkong_dma_nch

Overview:
Multi-channel, parametrised successor to the single-channel sprite DMA. Each channel copies a block from a source RAM (port B of a dual-port buffer) into a destination RAM (e.g. the object line buffer). Transfers are arbitrated by fixed priority. The CPU bus is taken with the existing HRQ/HLDA handshake, and the block runs on the 3.072 MHz CPU clock enable. A per-channel fill mode writes a constant value instead of copying, for clearing buffers.

Parameters:
CHANNELS, 2, number of independent DMA channels (1..8)
AW, 10, source and destination address width
LW, 10, transfer length counter width
DW, 8, data width

Ports:
I_CLK  in  1  system clock (24.576 MHz)
I_RESET  in  1  synchronous reset, active-high
I_CLK_EN  in  1  step enable; all state advances only when high
I_DMA_TRIG  in  CHANNELS  per-channel trigger; rising edge requests a transfer
I_SRC_BASE  in  CHANNELS*AW  per-channel source base; channel n in bits [n*AW +: AW]
I_DST_BASE  in  CHANNELS*AW  per-channel destination base
I_LEN  in  CHANNELS*LW  per-channel byte count
I_FILL  in  CHANNELS  per-channel mode: 1 = fill with I_FILL_D, 0 = copy
I_FILL_D  in  DW  fill value
I_DMA_DS  in  DW  source RAM read data; valid one CE step after O_DMA_CES
I_HLDA  in  1  bus hold acknowledge
O_HRQ  out  1  bus hold request
O_DMA_AS  out  AW  source address
O_DMA_CES  out  1  source read enable
O_DMA_AD  out  AW  destination address
O_DMA_DD  out  DW  destination write data
O_DMA_CED  out  1  destination write enable
O_BUSY  out  1  high from leaving IDLE until DONE completes
O_ACT_CH  out  3  index of the active channel
O_DONE  out  CHANNELS  one-I_CLK pulse on the completing channel

Behaviour:
- Reset: all outputs 0, pending flags cleared, trigger edge history loaded with current I_DMA_TRIG (no false edge). Reset mid-transfer aborts immediately and drops O_HRQ on the next edge.
- Trigger edge detect is sampled on CE steps only. An edge sets pending[n]. A pending flag already set stays set (triggers do not queue).
- States:
  - IDLE: on CE, if any pending, select the lowest-index pending channel n, clear pending[n], latch src/dst/len/fill, idx=0.
    - If len==0: go to DONE without asserting HRQ.
    - Otherwise: O_HRQ=1, O_BUSY=1, go to WAIT.
  - WAIT: on CE with I_HLDA=1, go to XFER. O_HRQ stays high.
  - XFER (pipelined), each CE step with I_HLDA=1:
    - if idx<len: O_DMA_AS=src+idx, O_DMA_CES=1 (CES=0 in fill mode);
    - if idx>=1: O_DMA_AD=dst+idx-1, O_DMA_DD = fill ? I_FILL_D : I_DMA_DS, O_DMA_CED=1;
    - idx++.
    - When idx==len after the final write step, go to DONE. XFER therefore lasts len+1 CE steps.
  - DONE: O_HRQ=0, CES=CED=0, O_DONE[n] high for exactly one I_CLK cycle, O_BUSY=0, return to IDLE.
- HLDA dropped during XFER: pause. CES and CED are forced to 0, idx and addresses hold, O_HRQ stays 1, and the transfer resumes on the first CE step with HLDA=1. No byte is skipped or duplicated. The read issued before the pause is reissued on resume.
- Address arithmetic wraps modulo 2^AW. len=2^LW-1 is legal.
- Retrigger of the active channel during its transfer sets pending, so the channel runs once more after DONE.
- Simultaneous triggers: the lower index runs first and the others stay pending. Between consecutive transfers HRQ drops for at least one CE step.
- Without CE: registered outputs hold, except O_DONE, which clears after one I_CLK.
- O_ACT_CH is valid while O_BUSY=1 and 0 otherwise.

Test Plan:
- Ch0 src=0x000, dst=0x100, len=4, copy, HLDA returned two CE steps after HRQ. Required: reads 0x000..0x003, writes 0x100..0x103 with the source data; XFER lasts 5 CE steps; one O_DONE[0] pulse, then HRQ=0.
- Ch0 and ch1 triggered on the same CE step. Required: ch0 completes first, HRQ drops for at least one step, then ch1 runs; O_DONE[0] precedes O_DONE[1].
- Ch1 fill mode, dst=0x3FE, len=4, I_FILL_D=0xAA. Required: CES never asserted; writes to 0x3FE, 0x3FF, 0x000, 0x001 (wrap), all 0xAA.
- HLDA deasserted for 3 CE steps mid-copy of len=8. Required: CES and CED are 0 during the pause; all 8 destination bytes are correct with no duplicate or missing writes.
- len=0 trigger. Required: HRQ never asserted; O_DONE pulse within 2 CE steps.
- I_RESET asserted during XFER. Required: HRQ, CES, CED and BUSY are 0 on the next clock; pending is cleared; a held-high trigger does not restart the transfer after reset.

Source files
------------

// File: rtl/dkong_dma_nch.sv
// rtl/dkong_dma_nch.sv - multi-channel fixed-priority block DMA with fill mode
// Copies or fills a block per channel under the HRQ/HLDA bus handshake, one step per CPU clock enable.
module dkong_dma_nch #(
    parameter int CHANNELS = 2,
    parameter int AW       = 10,
    parameter int LW       = 10,
    parameter int DW       = 8
) (
    input  logic                   I_CLK,
    input  logic                   I_RESET,
    input  logic                   I_CLK_EN,
    input  logic [CHANNELS-1:0]    I_DMA_TRIG,
    input  logic [CHANNELS*AW-1:0] I_SRC_BASE,
    input  logic [CHANNELS*AW-1:0] I_DST_BASE,
    input  logic [CHANNELS*LW-1:0] I_LEN,
    input  logic [CHANNELS-1:0]    I_FILL,
    input  logic [DW-1:0]          I_FILL_D,
    input  logic [DW-1:0]          I_DMA_DS,
    input  logic                   I_HLDA,
    output logic                   O_HRQ,
    output logic [AW-1:0]          O_DMA_AS,
    output logic                   O_DMA_CES,
    output logic [AW-1:0]          O_DMA_AD,
    output logic [DW-1:0]          O_DMA_DD,
    output logic                   O_DMA_CED,
    output logic                   O_BUSY,
    output logic [2:0]             O_ACT_CH,
    output logic [CHANNELS-1:0]    O_DONE
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [LW-1:0] ONE_L = LW'(1);

    logic [1:0]          state;
    logic [CHANNELS-1:0] trig_prev;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] edge_det;
    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] sel_mask;
    logic [CHANNELS-1:0] cur_mask;
    logic [CHANNELS-1:0] done_r;
    logic                sel_found;
    logic [2:0]          sel_ch;
    logic [2:0]          cur_ch;
    logic [AW-1:0]       sel_src;
    logic [AW-1:0]       sel_dst;
    logic [LW-1:0]       sel_len;
    logic                sel_fill;

    logic [AW-1:0]       src_r;
    logic [AW-1:0]       dst_r;
    logic [LW-1:0]       len_r;
    logic [LW-1:0]       idx;
    logic                fill_r;
    logic                stalled;
    logic                busy;
    logic                hrq;
    logic                ces;
    logic                ced;
    logic [AW-1:0]       as_r;
    logic [AW-1:0]       ad_r;
    logic [DW-1:0]       dd_r;

    // A trigger edge seen on this step is eligible for selection in the same step.
    always_comb begin
        edge_det  = I_DMA_TRIG & ~trig_prev;
        req       = pending | edge_det;
        sel_found = 1'b0;
        sel_ch    = 3'd0;
        sel_mask  = '0;
        sel_src   = '0;
        sel_dst   = '0;
        sel_len   = '0;
        sel_fill  = 1'b0;
        for (int n = CHANNELS - 1; n >= 0; n--) begin
            if (req[n]) begin
                sel_found   = 1'b1;
                sel_ch      = 3'(n);
                sel_mask    = '0;
                sel_mask[n] = 1'b1;
                sel_src     = I_SRC_BASE[n*AW +: AW];
                sel_dst     = I_DST_BASE[n*AW +: AW];
                sel_len     = I_LEN[n*LW +: LW];
                sel_fill    = I_FILL[n];
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        done_r <= '0;
        if (I_RESET) begin
            state     <= S_IDLE;
            trig_prev <= I_DMA_TRIG;
            pending   <= '0;
            cur_mask  <= '0;
            cur_ch    <= 3'd0;
            src_r     <= '0;
            dst_r     <= '0;
            len_r     <= '0;
            idx       <= '0;
            fill_r    <= 1'b0;
            stalled   <= 1'b0;
            busy      <= 1'b0;
            hrq       <= 1'b0;
            ces       <= 1'b0;
            ced       <= 1'b0;
            as_r      <= '0;
            ad_r      <= '0;
            dd_r      <= '0;
        end else if (I_CLK_EN) begin
            trig_prev <= I_DMA_TRIG;
            pending   <= req;
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        pending  <= req & ~sel_mask;
                        cur_mask <= sel_mask;
                        cur_ch   <= sel_ch;
                        src_r    <= sel_src;
                        dst_r    <= sel_dst;
                        len_r    <= sel_len;
                        fill_r   <= sel_fill;
                        idx      <= '0;
                        stalled  <= 1'b0;
                        if (sel_len == '0) begin
                            state <= S_DONE;
                        end else begin
                            hrq   <= 1'b1;
                            busy  <= 1'b1;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (I_HLDA) begin
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (!I_HLDA) begin
                        ces     <= 1'b0;
                        ced     <= 1'b0;
                        stalled <= 1'b1;
                    end else if (stalled && (idx != '0) && !fill_r) begin
                        // The source data of the read before the pause is gone; fetch it again.
                        as_r    <= src_r + AW'(idx - ONE_L);
                        ces     <= 1'b1;
                        ced     <= 1'b0;
                        stalled <= 1'b0;
                    end else begin
                        stalled <= 1'b0;
                        if (idx < len_r) begin
                            as_r <= src_r + AW'(idx);
                            ces  <= !fill_r;
                        end else begin
                            ces  <= 1'b0;
                        end
                        if (idx != '0) begin
                            ad_r <= dst_r + AW'(idx - ONE_L);
                            dd_r <= fill_r ? I_FILL_D : I_DMA_DS;
                            ced  <= 1'b1;
                        end else begin
                            ced  <= 1'b0;
                        end
                        if (idx == len_r) begin
                            state <= S_DONE;
                        end else begin
                            idx <= idx + ONE_L;
                        end
                    end
                end
                S_DONE: begin
                    hrq    <= 1'b0;
                    ces    <= 1'b0;
                    ced    <= 1'b0;
                    busy   <= 1'b0;
                    done_r <= cur_mask;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign O_HRQ     = hrq;
    assign O_DMA_AS  = as_r;
    assign O_DMA_CES = ces;
    assign O_DMA_AD  = ad_r;
    assign O_DMA_DD  = dd_r;
    assign O_DMA_CED = ced;
    assign O_BUSY    = busy;
    assign O_ACT_CH  = busy ? cur_ch : 3'd0;
    assign O_DONE    = done_r;

endmodule

// File: tb/tb_dkong_dma_nch.sv
// tb/tb_dkong_dma_nch.sv - directed self-checking bench for dkong_dma_nch
module tb_dkong_dma_nch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hlda = 1'b0;
    logic [1:0]  trig = 2'b00;
    logic [1:0]  fill = 2'b00;
    logic [19:0] src_base = '0;
    logic [19:0] dst_base = '0;
    logic [19:0] len = '0;
    logic [7:0]  fill_d = '0;
    logic [7:0]  ds = '0;
    logic [1:0]  ce_cnt = '0;
    logic        ce;

    logic        o_hrq;
    logic [9:0]  o_as;
    logic        o_ces;
    logic [9:0]  o_ad;
    logic [7:0]  o_dd;
    logic        o_ced;
    logic        o_busy;
    logic [2:0]  o_act;
    logic [1:0]  o_done;

    int n_chk = 0;
    int n_fail = 0;

    logic [9:0] wq_a[$];
    logic [7:0] wq_d[$];
    logic [9:0] rq_a[$];
    int ces_cnt = 0;
    int hrq_cnt = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;

    dkong_dma_nch #(.CHANNELS(2), .AW(10), .LW(10), .DW(8)) dut (
        .I_CLK      (clk),
        .I_RESET    (rst),
        .I_CLK_EN   (ce),
        .I_DMA_TRIG (trig),
        .I_SRC_BASE (src_base),
        .I_DST_BASE (dst_base),
        .I_LEN      (len),
        .I_FILL     (fill),
        .I_FILL_D   (fill_d),
        .I_DMA_DS   (ds),
        .I_HLDA     (hlda),
        .O_HRQ      (o_hrq),
        .O_DMA_AS   (o_as),
        .O_DMA_CES  (o_ces),
        .O_DMA_AD   (o_ad),
        .O_DMA_DD   (o_dd),
        .O_DMA_CED  (o_ced),
        .O_BUSY     (o_busy),
        .O_ACT_CH   (o_act),
        .O_DONE     (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ce_cnt <= ce_cnt + 2'd1;
    assign ce = (ce_cnt == 2'd3);

    function automatic logic [7:0] src_pat(input logic [9:0] a);
        return a[7:0] ^ 8'h5A ^ {a[9:8], 6'b000000};
    endfunction

    // Source RAM: output is only meaningful while a read is being issued.
    always @(posedge clk) ds <= o_ces ? src_pat(o_as) : 8'hEE;

    always @(posedge clk) begin
        if (ce) begin
            if (o_ced) begin
                wq_a.push_back(o_ad);
                wq_d.push_back(o_dd);
            end
            if (o_ces) begin
                rq_a.push_back(o_as);
                ces_cnt <= ces_cnt + 1;
            end
        end
        if (o_hrq) hrq_cnt <= hrq_cnt + 1;
        if (o_done[0]) done0_cnt <= done0_cnt + 1;
        if (o_done[1]) done1_cnt <= done1_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ce_step();
        @(negedge clk);
        while (!ce) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bw, br, d0, d1, h0, c0, st0, st1;
        logic [2:0] act_after;
        logic hrq_at_d0, busy_at_d0;
        logic [9:0] fa[4];

        repeat (3) ce_step();
        chk("rst_hrq", 32'(o_hrq), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_ces", 32'(o_ces), 0);
        chk("rst_ced", 32'(o_ced), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_act", 32'(o_act), 0);
        rst = 1'b0;

        // T1: ch0 copy 0x000 -> 0x100, len 4, HLDA two steps late
        src_base[9:0] = 10'h000; dst_base[9:0] = 10'h100; len[9:0] = 10'd4;
        ce_step();
        bw = wq_a.size(); br = rq_a.size();
        trig[0] = 1'b1;
        ce_step();
        chk("t1_hrq", 32'(o_hrq), 1);
        chk("t1_busy", 32'(o_busy), 1);
        ce_step();
        hlda = 1'b1;
        ce_step();
        chk("t1_no_read_before_xfer", 32'(o_ces), 0);
        ce_step();
        chk("t1_first_ces", 32'(o_ces), 1);
        chk("t1_first_as", 32'(o_as), 'h000);
        chk("t1_first_ced", 32'(o_ced), 0);
        repeat (3) ce_step();
        ce_step();
        chk("t1_last_ces", 32'(o_ces), 0);
        chk("t1_last_ced", 32'(o_ced), 1);
        chk("t1_last_ad", 32'(o_ad), 'h103);
        chk("t1_last_dd", 32'(o_dd), 32'(src_pat(10'h003)));
        chk("t1_busy_last", 32'(o_busy), 1);
        chk("t1_hrq_last", 32'(o_hrq), 1);
        ce_step();
        chk("t1_done", 32'(o_done), 'b01);
        chk("t1_hrq_off", 32'(o_hrq), 0);
        chk("t1_busy_off", 32'(o_busy), 0);
        @(posedge clk); #1;
        chk("t1_done_width", 32'(o_done), 0);
        chk("t1_nwr", wq_a.size() - bw, 4);
        chk("t1_nrd", rq_a.size() - br, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_wa%0d", i), 32'(wq_a[bw+i]), 'h100 + i);
            chk($sformatf("t1_wd%0d", i), 32'(wq_d[bw+i]), 32'(src_pat(10'(i))));
            chk($sformatf("t1_ra%0d", i), 32'(rq_a[br+i]), i);
        end
        hlda = 1'b0; trig = 2'b00;
        ce_step();

        // T2: simultaneous triggers, ch0 before ch1
        src_base[19:10] = 10'h010; dst_base[19:10] = 10'h200; len[19:10] = 10'd2;
        hlda = 1'b1;
        ce_step();
        bw = wq_a.size();
        st0 = -1; st1 = -1; act_after = 3'd7; hrq_at_d0 = 1'b1; busy_at_d0 = 1'b1;
        trig = 2'b11;
        for (int k = 1; k <= 40; k++) begin
            ce_step();
            if (o_done[0] && st0 < 0) begin
                st0 = k; hrq_at_d0 = o_hrq; busy_at_d0 = o_busy;
            end
            if (st0 >= 0 && k == st0 + 1) act_after = o_act;
            if (o_done[1] && st1 < 0) st1 = k;
            if (st1 >= 0) break;
        end
        chk("t2_done0_seen", 32'(st0 > 0), 1);
        chk("t2_order", 32'(st1 > st0), 1);
        chk("t2_hrq_gap", 32'(hrq_at_d0), 0);
        chk("t2_busy_gap", 32'(busy_at_d0), 0);
        chk("t2_act_ch1", 32'(act_after), 1);
        chk("t2_nwr", wq_a.size() - bw, 6);
        chk("t2_wa0", 32'(wq_a[bw]), 'h100);
        chk("t2_wa4", 32'(wq_a[bw+4]), 'h200);
        chk("t2_wd4", 32'(wq_d[bw+4]), 32'(src_pat(10'h010)));
        chk("t2_wa5", 32'(wq_a[bw+5]), 'h201);
        chk("t2_wd5", 32'(wq_d[bw+5]), 32'(src_pat(10'h011)));
        trig = 2'b00; hlda = 1'b0;
        ce_step();

        // T3: ch1 fill across the address wrap
        src_base[19:10] = 10'h050; dst_base[19:10] = 10'h3FE; len[19:10] = 10'd4;
        fill = 2'b10; fill_d = 8'hAA; hlda = 1'b1;
        ce_step();
        bw = wq_a.size(); c0 = ces_cnt; d1 = done1_cnt;
        trig[1] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            ce_step();
            if (o_done[1]) break;
        end
        ce_step();
        chk("t3_done", done1_cnt - d1, 1);
        chk("t3_no_ces", ces_cnt - c0, 0);
        chk("t3_nwr", wq_a.size() - bw, 4);
        fa[0] = 10'h3FE; fa[1] = 10'h3FF; fa[2] = 10'h000; fa[3] = 10'h001;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_wa%0d", i), 32'(wq_a[bw+i]), 32'(fa[i]));
            chk($sformatf("t3_wd%0d", i), 32'(wq_d[bw+i]), 'hAA);
        end
        trig = 2'b00; fill = 2'b00; hlda = 1'b0;
        ce_step();

        // T4: HLDA drops for three steps in the middle of a len=8 copy
        src_base[9:0] = 10'h020; dst_base[9:0] = 10'h140; len[9:0] = 10'd8;
        hlda = 1'b1;
        ce_step();
        bw = wq_a.size(); d0 = done0_cnt;
        trig[0] = 1'b1;
        repeat (5) ce_step();
        hlda = 1'b0;
        for (int p = 0; p < 3; p++) begin
            ce_step();
            chk($sformatf("t4_pause_ces%0d", p), 32'(o_ces), 0);
            chk($sformatf("t4_pause_ced%0d", p), 32'(o_ced), 0);
            chk($sformatf("t4_pause_hrq%0d", p), 32'(o_hrq), 1);
        end
        hlda = 1'b1;
        ce_step();
        chk("t4_reissue_ces", 32'(o_ces), 1);
        chk("t4_reissue_as", 32'(o_as), 'h022);
        chk("t4_reissue_ced", 32'(o_ced), 0);
        for (int k = 0; k < 30; k++) begin
            ce_step();
            if (o_done[0]) break;
        end
        ce_step();
        chk("t4_done", done0_cnt - d0, 1);
        chk("t4_nwr", wq_a.size() - bw, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_wa%0d", i), 32'(wq_a[bw+i]), 'h140 + i);
            chk($sformatf("t4_wd%0d", i), 32'(wq_d[bw+i]), 32'(src_pat(10'(32'h20 + i))));
        end
        trig = 2'b00; hlda = 1'b0;
        ce_step();

        // T5: zero-length request completes without bus request
        len[19:10] = 10'd0;
        ce_step();
        h0 = hrq_cnt; d1 = done1_cnt;
        trig[1] = 1'b1;
        ce_step();
        chk("t5_hrq_step1", 32'(o_hrq), 0);
        ce_step();
        chk("t5_done_step2", 32'(o_done), 'b10);
        ce_step();
        chk("t5_hrq_never", hrq_cnt - h0, 0);
        chk("t5_done_once", done1_cnt - d1, 1);
        trig = 2'b00;
        ce_step();

        // T6: reset during XFER with triggers held high
        src_base[9:0] = 10'h000; dst_base[9:0] = 10'h100; len[9:0] = 10'd8; len[19:10] = 10'd3;
        hlda = 1'b1;
        ce_step();
        trig[0] = 1'b1;
        repeat (3) ce_step();
        trig[1] = 1'b1;
        ce_step();
        chk("t6_in_xfer", 32'(o_ces), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_hrq", 32'(o_hrq), 0);
        chk("t6_rst_ces", 32'(o_ces), 0);
        chk("t6_rst_ced", 32'(o_ced), 0);
        chk("t6_rst_busy", 32'(o_busy), 0);
        repeat (2) ce_step();
        rst = 1'b0;
        h0 = hrq_cnt; d0 = done0_cnt; d1 = done1_cnt;
        repeat (10) ce_step();
        chk("t6_no_restart_hrq", hrq_cnt - h0, 0);
        chk("t6_no_done0", done0_cnt - d0, 0);
        chk("t6_no_done1", done1_cnt - d1, 0);
        chk("t6_idle_busy", 32'(o_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
